sha256_sequencer: RTL and testbench

SHA256_SEQUENCER -- requirements
Module: sha256_sequencer

---
 rtl/sha256_sequencer_if.sv | 31 +++
 rtl/sha256_sequencer.sv | 130 +++++++++++++
 tb/tb_sha256_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_sequencer_if.sv
// Block, digest and engine-side bundles of the SHA-256 block sequencer.
// The slave modport is the sequencer's view, master the environment's.
interface sha256_sequencer_if;
   logic               blk_valid;
   logic               blk_ready;
   logic               blk_first;
   logic               blk_last;
   logic [63:0][7:0]   blk_data;
   logic               dig_valid;
   logic               dig_ready;
   logic [7:0][31:0]   dig_data;
   logic               eng_in_valid;
   logic [7:0][31:0]   eng_state;
   logic [63:0][7:0]   eng_data;
   logic               eng_out_valid;
   logic [7:0][31:0]   eng_res;

   modport slave (
      input  blk_valid, blk_first, blk_last, blk_data,
      input  dig_ready, eng_out_valid, eng_res,
      output blk_ready, dig_valid, dig_data,
      output eng_in_valid, eng_state, eng_data
   );

   modport master (
      output blk_valid, blk_first, blk_last, blk_data,
      output dig_ready, eng_out_valid, eng_res,
      input  blk_ready, dig_valid, dig_data,
      input  eng_in_valid, eng_state, eng_data
   );
endinterface

// File: rtl/sha256_sequencer.sv
// Chains 512-bit blocks through an external SHA-256 compression engine
// and emits the final digest once the last block of a message completes.
module sha256_sequencer #(
   parameter int TIMEOUT = 80
) (
   input  logic                 clk,
   input  logic                 rst,
   sha256_sequencer_if.slave    bus,
   output logic                 busy,
   output logic                 err,
   output logic [31:0]          blk_count
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
   localparam logic [7:0][31:0] IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_e;

   state_e           state_q, state_d;
   logic [7:0][31:0] chain_q, chain_d;
   logic [63:0][7:0] blk_q, blk_d;
   logic             last_q, last_d;
   logic             ok_q, ok_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [31:0]      count_q, count_d;
   logic [CW-1:0]    cnt_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         chain_q <= IV;
         blk_q   <= '0;
         last_q  <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         chain_q <= chain_d;
         blk_q   <= blk_d;
         last_q  <= last_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      chain_d = chain_q;
      blk_d   = blk_q;
      last_d  = last_q;
      ok_d    = ok_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      cnt_inc = cnt_q + CW'(1);
      unique case (state_q)
         S_IDLE: begin
            if (bus.blk_valid) begin
               if (bus.blk_first) begin
                  chain_d = IV;
                  ok_d    = 1'b1;
                  err_d   = 1'b0;
                  blk_d   = bus.blk_data;
                  last_d  = bus.blk_last;
                  state_d = S_ISSUE;
               end else if (ok_q) begin
                  blk_d   = bus.blk_data;
                  last_d  = bus.blk_last;
                  state_d = S_ISSUE;
               end else begin
                  // continuation without a live chain: drop it
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.eng_out_valid) begin
               chain_d = bus.eng_res;
               count_d = count_q + 32'd1;
               if (last_q) begin
                  ok_d    = 1'b0;
                  state_d = S_OUT;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TO_LIM) begin
                  err_d   = 1'b1;
                  ok_d    = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         S_OUT: begin
            if (bus.dig_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.blk_ready    = (state_q == S_IDLE);
   assign bus.dig_valid    = (state_q == S_OUT);
   assign bus.eng_in_valid = (state_q == S_ISSUE);
   assign bus.dig_data     = chain_q;
   assign bus.eng_state    = chain_q;
   assign bus.eng_data     = blk_q;
   assign busy             = (state_q != S_IDLE);
   assign err              = err_q;
   assign blk_count        = count_q;

endmodule

// File: tb/tb_sha256_sequencer.sv
// Directed bench for sha256_sequencer with a behavioural SHA-256 engine
// that answers eng_in_valid with a real compression result.
module tb_sha256_sequencer;

   localparam int TO = 80;

   localparam logic [255:0] IV_BE =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [255:0] D_ABC =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_TWO =
      256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] M2 [14] = '{
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071
   };

   typedef struct {
      logic         first;
      logic         last;
      logic [511:0] data;
      logic         accept;
      logic [255:0] digest;
      logic         err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic        err;
   logic [31:0] blk_count;

   sha256_sequencer_if bus ();

   sha256_sequencer #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .err       (err),
      .blk_count (blk_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_dig = 0;
   int n_iss = 0;
   int n_dv = 0;
   logic [31:0] exp_cnt;

   always @(posedge clk) begin
      if (bus.dig_valid && bus.dig_ready) n_dig <= n_dig + 1;
      if (bus.eng_in_valid) n_iss <= n_iss + 1;
      if (bus.dig_valid) n_dv <= n_dv + 1;
   end

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(
      input logic [255:0] hs, input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] a, bb, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int t = 0; t < 16; t++) w[t] = b[32*t +: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      a = hs[31:0];    bb = hs[63:32];   c = hs[95:64];   d = hs[127:96];
      e = hs[159:128]; f = hs[191:160];  g = hs[223:192]; h = hs[255:224];
      for (int t = 0; t < 64; t++) begin
         s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
         s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
         t2 = s0 + ((a & bb) ^ (a & c) ^ (bb & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = bb; bb = a; a = t1 + t2;
      end
      return {hs[255:224] + h, hs[223:192] + g, hs[191:160] + f,
              hs[159:128] + e, hs[127:96] + d, hs[95:64] + c,
              hs[63:32] + bb, hs[31:0] + a};
   endfunction

   // digest constants are written H0-first; the bus carries word 0 at the LSBs
   function automatic logic [255:0] to_le(input logic [255:0] be);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = be[255-32*i -: 32];
      return r;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk256(input string nm, input logic [255:0] act,
                         input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic offer(input logic f, input logic l, input logic [511:0] d);
      bus.blk_first = f;
      bus.blk_last  = l;
      bus.blk_data  = d;
      bus.blk_valid = 1'b1;
      @(negedge clk);
      bus.blk_valid = 1'b0;
      bus.blk_first = 1'b0;
      bus.blk_last  = 1'b0;
   endtask

   task automatic engine_respond(input int lat);
      repeat (lat) @(negedge clk);
      bus.eng_res       = compress(bus.eng_state, bus.eng_data);
      bus.eng_out_valid = 1'b1;
      exp_cnt++;
      @(negedge clk);
      bus.eng_out_valid = 1'b0;
   endtask

   task automatic take_digest();
      bus.dig_ready = 1'b1;
      @(negedge clk);
      bus.dig_ready = 1'b0;
   endtask

   vec_t         vt [6];
   logic [511:0] abc, b1, b2;
   int           iss0, dig0, dv0;

   initial begin
      abc = '0;
      abc[31:0] = 32'h61626380;
      abc[511:480] = 32'h00000018;
      b1 = '0;
      for (int i = 0; i < 14; i++) b1[32*i +: 32] = M2[i];
      b1[479:448] = 32'h80000000;
      b2 = '0;
      b2[511:480] = 32'h000001c0;

      vt[0] = '{1'b0, 1'b1, abc, 1'b0, '0, 1'b1};
      vt[1] = '{1'b1, 1'b1, abc, 1'b1, D_ABC, 1'b0};
      vt[2] = '{1'b1, 1'b0, b1, 1'b1, '0, 1'b0};
      vt[3] = '{1'b0, 1'b1, b2, 1'b1, D_TWO, 1'b0};
      vt[4] = '{1'b0, 1'b1, abc, 1'b0, '0, 1'b1};
      vt[5] = '{1'b1, 1'b1, abc, 1'b1, D_ABC, 1'b0};

      bus.blk_valid = 1'b0;
      bus.blk_first = 1'b0;
      bus.blk_last  = 1'b0;
      bus.blk_data  = '0;
      bus.dig_ready = 1'b0;
      bus.eng_out_valid = 1'b0;
      bus.eng_res = '0;
      exp_cnt = '0;

      repeat (3) @(negedge clk);
      chk1("rst_blk_ready", bus.blk_ready, 1'b1);
      chk1("rst_dig_valid", bus.dig_valid, 1'b0);
      chk1("rst_eng_in_valid", bus.eng_in_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err", err, 1'b0);
      chk32("rst_blk_count", blk_count, 32'd0);
      chk256("rst_chain_iv", bus.eng_state, to_le(IV_BE));
      chk1("rst_blk_reg_zero", bus.eng_data == '0, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      foreach (vt[i]) begin
         iss0 = n_iss;
         dig0 = n_dig;
         offer(vt[i].first, vt[i].last, vt[i].data);
         if (!vt[i].accept) begin
            chk1("drop_blk_ready", bus.blk_ready, 1'b1);
            chk1("drop_no_issue", bus.eng_in_valid, 1'b0);
            @(negedge clk);
            chk32("drop_issue_count", n_iss, iss0);
            chk32("drop_blk_count", blk_count, exp_cnt);
         end else begin
            chk1("issue_latency", bus.eng_in_valid, 1'b1);
            engine_respond(3);
            chk32("blk_count", blk_count, exp_cnt);
            if (vt[i].last) begin
               chk1("dig_latency", bus.dig_valid, 1'b1);
               chk256("digest", bus.dig_data, to_le(vt[i].digest));
               take_digest();
               chk32("one_dig_episode", n_dig, dig0 + 1);
            end else begin
               chk1("mid_no_dig", bus.dig_valid, 1'b0);
               chk1("mid_ready", bus.blk_ready, 1'b1);
            end
         end
         chk1("err_flag", err, vt[i].err);
      end

      // digest held while downstream stalls
      offer(1'b1, 1'b1, abc);
      engine_respond(2);
      for (int c = 0; c < 10; c++) begin
         chk1("stall_dig_valid", bus.dig_valid, 1'b1);
         chk256("stall_dig_data", bus.dig_data, to_le(D_ABC));
         chk1("stall_blk_ready", bus.blk_ready, 1'b0);
         chk1("stall_eng_in", bus.eng_in_valid, 1'b0);
         @(negedge clk);
      end
      take_digest();
      chk1("stall_done_busy", busy, 1'b0);

      // silent engine: timeout exactly TO cycles into WAIT
      offer(1'b1, 1'b1, abc);
      repeat (TO) @(negedge clk);
      chk1("to_still_busy", busy, 1'b1);
      chk1("to_no_err_yet", err, 1'b0);
      @(negedge clk);
      chk1("to_idle", busy, 1'b0);
      chk1("to_err", err, 1'b1);
      chk32("to_blk_count", blk_count, exp_cnt);
      bus.eng_res = {8{32'hdeadbeef}};
      bus.eng_out_valid = 1'b1;
      @(negedge clk);
      bus.eng_out_valid = 1'b0;
      chk32("late_strobe_ignored", blk_count, exp_cnt);
      chk1("late_strobe_idle", busy, 1'b0);
      offer(1'b1, 1'b1, abc);
      chk1("to_err_cleared", err, 1'b0);
      engine_respond(4);
      chk256("to_recover_digest", bus.dig_data, to_le(D_ABC));
      take_digest();

      // reset while waiting on the engine, then a stale strobe
      offer(1'b1, 1'b0, b1);
      @(negedge clk);
      chk1("mid_wait_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk1("async_rst_busy", busy, 1'b0);
      chk32("async_rst_count", blk_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = '0;
      dv0 = n_dv;
      bus.eng_res = {8{32'h01234567}};
      bus.eng_out_valid = 1'b1;
      @(negedge clk);
      bus.eng_out_valid = 1'b0;
      @(negedge clk);
      chk1("post_rst_busy", busy, 1'b0);
      chk1("post_rst_dig_valid", bus.dig_valid, 1'b0);
      chk1("post_rst_ready", bus.blk_ready, 1'b1);
      chk1("post_rst_eng_in", bus.eng_in_valid, 1'b0);
      chk1("post_rst_err", err, 1'b0);
      chk32("post_rst_count", blk_count, exp_cnt);
      chk256("post_rst_chain", bus.eng_state, to_le(IV_BE));
      chk1("post_rst_blk_zero", bus.eng_data == '0, 1'b1);
      chk32("post_rst_no_dv", n_dv, dv0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
